// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: one shared prescaled period counter (edge or center aligned)
// feeding CH duty comparators, with period/duty/mode double-buffered to period boundaries.
module pwm_multi_ch #(
    parameter int CH    = 4,
    parameter int W     = 8,
    parameter int PRE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              mode,
    input  logic [PRE_W-1:0]  prescale,
    input  logic [W-1:0]      period,
    input  logic [CH*W-1:0]   duty,
    input  logic              load,
    output logic [CH-1:0]     pulse,
    output logic              tick
);

    logic [PRE_W-1:0] pcnt;
    logic [W-1:0]     cnt;
    logic             dir;
    logic             pend;

    logic             mode_s, mode_a;
    logic [W-1:0]     period_s, period_a;
    logic [CH*W-1:0]  duty_s, duty_a;

    logic             step;
    logic             last;
    logic             boundary;
    logic             xfer;
    logic [W-1:0]     cnt_next;
    logic             dir_next;
    logic [CH-1:0]    pulse_d;

    // In center mode with P = 1 the up-count reaches 1 with dir still 0, so that
    // step must also close the period to keep it at 2P steps.
    always_comb begin
        step = en && (pcnt == prescale);
        if (mode_a)
            last = (period_a == '0) || ((cnt == W'(1)) && (dir || (period_a == W'(1))));
        else
            last = (cnt == period_a);
        boundary = step && last;
        xfer     = !en || boundary;

        cnt_next = cnt;
        dir_next = dir;
        if (step) begin
            if (last) begin
                cnt_next = '0;
                dir_next = 1'b0;
            end else if (!mode_a) begin
                cnt_next = cnt + 1'b1;
            end else if (!dir) begin
                if (cnt == period_a) begin
                    cnt_next = cnt - 1'b1;
                    dir_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end else begin
                cnt_next = cnt - 1'b1;
            end
        end

        pulse_d = '0;
        for (int i = 0; i < CH; i++)
            pulse_d[i] = (cnt < duty_a[i*W +: W]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt  <= '0;
            cnt   <= '0;
            dir   <= 1'b0;
            pulse <= '0;
            tick  <= 1'b0;
        end else if (!en) begin
            pcnt  <= '0;
            cnt   <= '0;
            dir   <= 1'b0;
            pulse <= '0;
            tick  <= 1'b0;
        end else begin
            pcnt  <= step ? '0 : pcnt + 1'b1;
            cnt   <= cnt_next;
            dir   <= dir_next;
            pulse <= pulse_d;
            tick  <= boundary;
        end
    end

    // A load landing on a transfer cycle bypasses the shadow so the newest values win.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend     <= 1'b0;
            mode_s   <= 1'b0;
            period_s <= '0;
            duty_s   <= '0;
            mode_a   <= 1'b0;
            period_a <= '0;
            duty_a   <= '0;
        end else begin
            if (load) begin
                mode_s   <= mode;
                period_s <= period;
                duty_s   <= duty;
            end
            if (xfer && load) begin
                mode_a   <= mode;
                period_a <= period;
                duty_a   <= duty;
                pend     <= 1'b0;
            end else if (xfer && pend) begin
                mode_a   <= mode_s;
                period_a <= period_s;
                duty_a   <= duty_s;
                pend     <= 1'b0;
            end else if (load) begin
                pend     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: per-cycle sample patterns compared against hand-derived masks.
module tb_pwm_multi_ch;

    localparam int CH    = 4;
    localparam int W     = 8;
    localparam int PRE_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             mode;
    logic [PRE_W-1:0] prescale;
    logic [W-1:0]     period;
    logic [CH*W-1:0]  duty;
    logic             load;
    logic [CH-1:0]    pulse;
    logic             tick;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_wait;
    int          pch;
    int          nticks;
    int          hi [CH];
    logic [63:0] ppat;
    logic [63:0] tpat;

    always #5 clk = ~clk;

    pwm_multi_ch #(.CH(CH), .W(W), .PRE_W(PRE_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .prescale (prescale),
        .period   (period),
        .duty     (duty),
        .load     (load),
        .pulse    (pulse),
        .tick     (tick)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        ppat   = '0;
        tpat   = '0;
        nticks = 0;
        for (int c = 0; c < CH; c++) hi[c] = 0;
    endtask

    task automatic sample(input int i);
        if (pulse[pch]) ppat[i] = 1'b1;
        if (tick) begin
            tpat[i] = 1'b1;
            nticks++;
        end
        for (int c = 0; c < CH; c++)
            if (pulse[c]) hi[c]++;
    endtask

    task automatic measure(input int n);
        clear_stats();
        for (int i = 0; i < n; i++) begin
            sample(i);
            @(negedge clk);
        end
    endtask

    // Stop, load, and restart on the very next clock: only a one-clock stopped
    // transfer gets the new values active in time for the first period.
    task automatic stop_load(input logic m, input logic [W-1:0] p, input logic [CH*W-1:0] d,
                             input logic [PRE_W-1:0] pre, input string tag);
        @(negedge clk);
        en       = 1'b0;
        mode     = m;
        period   = p;
        duty     = d;
        prescale = pre;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check({tag, "_stop_pulse"}, pulse, 0);
        check({tag, "_stop_tick"}, tick, 0);
        en = 1'b1;
    endtask

    task automatic wait_tick(input string tag, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < budget);
        check({tag, "_tick_seen"}, tick, 1);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0;
        prescale = '0; period = '0; duty = '0; pch = 0;
        #12;
        check("reset_pulse", pulse, 0);
        check("reset_tick", tick, 0);
        @(negedge clk);
        reset = 1'b0;

        // edge mode, P=9, duties ch3..ch0 = 255,10,3,0
        stop_load(1'b0, 8'd9, 32'hFF0A0300, 4'd0, "edge");
        wait_tick("edge_first", 40, n_wait);
        check("edge_first_len", n_wait, 10);
        pch = 1;
        measure(20);
        check("edge_tick_pat", tpat, 64'h401);
        check("edge_ch1_pat", ppat, 64'h380E);
        check("edge_ch0_hi", hi[0], 0);
        check("edge_ch2_hi", hi[2], 20);
        check("edge_ch3_hi", hi[3], 20);

        // prescale=2, P=4, duty0=2: 15-clock period, high for 6 clocks after the tick cycle
        pch = 0;
        stop_load(1'b0, 8'd4, 32'h2, 4'd2, "pre");
        wait_tick("pre_first", 60, n_wait);
        check("pre_first_len", n_wait, 15);
        measure(30);
        check("pre_tick_pat", tpat, 64'h8001);
        check("pre_pulse_pat", ppat, 64'h3F007E);

        // shadow update mid-period, then a load coincident with a boundary
        stop_load(1'b0, 8'd9, 32'h5, 4'd0, "shadow");
        wait_tick("shadow_first", 40, n_wait);
        clear_stats();
        for (int i = 0; i < 40; i++) begin
            sample(i);
            if (i == 3)  begin period = 8'd4; duty = 32'h1; load = 1'b1; end
            if (i == 4)  load = 1'b0;
            if (i == 24) begin period = 8'd9; duty = 32'h5; load = 1'b1; end
            if (i == 25) load = 1'b0;
            @(negedge clk);
        end
        check("shadow_tick_pat", tpat, 64'h802108401);
        check("shadow_pulse_pat", ppat, 64'hF07C21083E);

        // center mode, P=4
        stop_load(1'b1, 8'd4, 32'h2, 4'd0, "center");
        wait_tick("center_first", 40, n_wait);
        check("center_first_len", n_wait, 8);
        measure(16);
        check("center_tick_pat", tpat, 64'h101);
        check("center_pulse_pat", ppat, 64'h707);

        stop_load(1'b1, 8'd4, 32'h5, 4'd0, "center_full");
        wait_tick("center_full_first", 40, n_wait);
        measure(16);
        check("center_full_pulse", ppat, 64'hFFFF);
        check("center_full_tick", tpat, 64'h101);

        // P=0: every step is a boundary
        stop_load(1'b0, 8'd0, 32'h1, 4'd0, "p0");
        wait_tick("p0_first", 10, n_wait);
        check("p0_first_len", n_wait, 1);
        measure(8);
        check("p0_pulse_pat", ppat, 64'hFF);
        check("p0_tick_pat", tpat, 64'hFF);

        // stopped: outputs forced low even though duty would give constant high
        en = 1'b0;
        @(negedge clk);
        measure(6);
        check("hold_pulse_pat", ppat, 0);
        check("hold_tick_pat", tpat, 0);

        stop_load(1'b0, 8'd0, 32'h0, 4'd0, "p0_zero");
        wait_tick("p0_zero_first", 10, n_wait);
        measure(8);
        check("p0_zero_pulse", ppat, 0);
        check("p0_zero_tick", tpat, 64'hFF);

        // asynchronous reset while pulse[1] is high
        stop_load(1'b0, 8'd9, 32'h0500, 4'd0, "rst");
        n_wait = 0;
        while (!pulse[1] && n_wait < 20) begin
            @(negedge clk);
            n_wait++;
        end
        check("rst_pulse1_high", pulse[1], 1);
        #2 reset = 1'b1;
        #1;
        check("rst_async_pulse", pulse, 0);
        check("rst_async_tick", tick, 0);
        @(negedge clk);
        reset = 1'b0;
        pch = 1;
        measure(20);
        check("rst_after_pulse", hi[0] + hi[1] + hi[2] + hi[3], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_multi_ch.md
# pwm_multi_ch

Parametrised multi-channel PWM generator, the successor to the single-channel 4-bit enhanced PWM. It drives `CH` independent duty cycles from one shared period counter. The period counter has a programmable clock prescaler and supports edge-aligned or center-aligned counting. Period, duty and mode are double-buffered so updates take effect only at a period boundary, and `tick` marks each boundary for downstream sampling or interrupt logic.

## Interface
- `CH`, 4: number of PWM channels.
- `W`, 8: counter, period and duty width in bits.
- `PRE_W`, 4: prescaler width in bits.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  run enable. Low means stopped and outputs held low.
- `mode`  in  1  0 = edge-aligned, 1 = center-aligned. Shadowed.
- `prescale`  in  PRE_W  one count step every `prescale+1` clocks. Not shadowed; sampled live.
- `period`  in  W  period value P. Shadowed.
- `duty`  in  CH*W  channel i duty at bits [i*W +: W]. Shadowed.
- `load`  in  1  one-clock strobe that captures `mode`, `period` and `duty` into the shadow registers.
- `pulse`  out  CH  PWM outputs, registered.
- `tick`  out  1  one-clock pulse at each period boundary, registered.

## Operation
- **Prescaler.** `pcnt` counts 0..`prescale`, then wraps. A step occurs in the cycle where `pcnt == prescale`. With `prescale = 0`, a step occurs every clock.
- **Edge mode.** On each step, `cnt` advances 0,1,…,P,0,…
  - One period is P+1 steps.
  - The boundary is the step taken while `cnt == P`.
- **Center mode.** `cnt` counts 0,1,…,P then P-1,…,1,0, using a direction register `dir` (0 = up, 1 = down).
  - One period is 2P steps.
  - The boundary is the step taken while `cnt == 1 && dir == 1`.
  - At that step `cnt` goes to 0 and `dir` goes to 0.
  - `dir` flips to 1 on the step taken at `cnt == P`.
- **P = 0, either mode.** `cnt` stays at 0 and every step is a boundary.
- **Compare.** `pulse[i]` is registered as `run && (cnt < duty_a[i])`, where `run = en` and `duty_a` is the active duty.
  - Duty 0 gives a constant-low output.
  - Any duty > P (edge mode) or > P (center mode) gives a constant-high output.
  - In center mode the high time is symmetric about `cnt = 0`: 2·duty−1 steps per period when 1 ≤ duty ≤ P.
- **Shadow registers.** A `load` writes `mode`, `period` and `duty` into the shadow registers and sets `pend`.
  - At a boundary with `pend = 1`, the active registers take the shadow values and `pend` clears.
  - The boundary also resets `cnt` to 0 and `dir` to 0.
  - If `load` coincides with a boundary, the newly presented input values go directly to the active registers and `pend` ends at 0.
  - A second `load` before a boundary overwrites the shadow; last write wins.
- **Stopped (`en = 0`).**
  - `pcnt`, `cnt` and `dir` are held at 0.
  - `pulse` = 0 and `tick` = 0.
  - If `pend` is set, or `load` is high, the active registers update every clock (immediate transfer).
  - After `en` rises, counting starts from `cnt = 0` on the next step.
- **Reset.** Asynchronous; takes effect immediately, including mid-period, and discards any pending shadow. Every register clears:
  - `pcnt`, `cnt`, `dir`, `pend` = 0.
  - Active and shadow period, duty and mode = 0 (edge mode).
  - `pulse` = 0 and `tick` = 0.

## Timing
- `pulse` and `tick` lag the `cnt` value that produced them by exactly 1 clock.
- `tick` is high for exactly one clock, in the cycle after the boundary step.
- Period length in clocks:
  - Edge mode: (P+1)·(prescale+1).
  - Center mode: 2P·(prescale+1).
  - P = 0: prescale+1.
- Latency of a `load`:
  - While running: new values apply to the first `cnt = 0` after the next boundary.
  - While stopped: the active registers update one clock after the `load`.
- A change to `prescale` takes effect on the next `pcnt` comparison.
  - If `prescale` is reduced below the current `pcnt`, `pcnt` wraps through its full range.

## Test plan
- **Reset mid-run.** Edge mode, P = 9, duty1 = 5; assert `reset` while `pulse[1]` = 1. Expect `pulse` = 0 and `tick` = 0 immediately. After release with `en = 1`, all outputs stay 0 (active duty = 0).
- **Edge duties.** `prescale` = 0, P = 9, duty = {255, 10, 3, 0} (ch3..ch0). Expect:
  - `tick` every 10 clocks.
  - ch0 always 0.
  - ch1 high 3 of every 10 clocks.
  - ch2 and ch3 always 1.
- **Prescaler.** `prescale` = 2, P = 4, duty0 = 2. Expect a period of 15 clocks, with `pulse[0]` high for the first 6 clocks after each `tick`-aligned period start.
- **Shadow update.** Running P = 9, duty0 = 5; pulse `load` with P = 4, duty0 = 1 at `cnt = 3`. Expect:
  - The current period finishes with 5 of 10 clocks high.
  - After `tick`, periods of 5 clocks with 1 clock high.
  - `load` coincident with the boundary step applies at that same boundary.
- **Center mode.** P = 4, duty0 = 2, `prescale` = 0. Expect:
  - `cnt` sequence 0,1,2,3,4,3,2,1.
  - `tick` every 8 clocks.
  - `pulse[0]` high 3 of 8 clocks (`cnt` = 1, 0, 1 around the boundary).
  - With duty0 = 5, `pulse[0]` is constantly high.
- **Enable and degenerate cases.**
  - `en` = 0: `pulse` = 0, and a `load` updates the active registers in 1 clock. On `en` rising, the first period starts at `cnt = 0`.
  - P = 0, duty0 = 1: `pulse[0]` always 1 and `tick` every clock.
  - P = 0, duty0 = 0: `pulse[0]` always 0.
